// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with overflow trap handling: captures EX results, squashes
// on flush, and parks in EXC_HOLD after a trapped overflow until the handler acknowledges.
module ex_mem_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        EX_valid,
    input  logic [3:0]  CTRL,
    input  logic [15:0] ALU_Result,
    input  logic [15:0] Remainder,
    input  logic        Overflow_flag,
    input  logic [3:0]  EX_dest,
    input  logic        EX_RegWrite,
    input  logic        EX_MemRead,
    input  logic        EX_MemWrite,
    input  logic [15:0] EX_StoreData,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Exc_ack,
    output logic        MEM_valid,
    output logic [15:0] MEM_Result,
    output logic [15:0] MEM_Remainder,
    output logic [15:0] MEM_StoreData,
    output logic [3:0]  MEM_dest,
    output logic        MEM_RegWrite,
    output logic        MEM_MemRead,
    output logic        MEM_MemWrite,
    output logic        MEM_R15Write,
    output logic        Busy,
    output logic        Exc_req,
    output logic [1:0]  Exc_code,
    output logic [7:0]  Ovf_count
);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] EXC_HOLD = 1'b1;

    localparam logic [3:0] OP_MUL = 4'd1;
    localparam logic [3:0] OP_DIV = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd14;
    localparam logic [3:0] OP_ADD = 4'd15;

    logic [0:0]  state_q, state_d;
    logic        valid_q, valid_d;
    logic [15:0] result_q, result_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] store_q, store_d;
    logic [3:0]  dest_q, dest_d;
    logic        regW_q, regW_d;
    logic        memR_q, memR_d;
    logic        memW_q, memW_d;
    logic        r15W_q, r15W_d;
    logic        excReq_q, excReq_d;
    logic [1:0]  excCode_q, excCode_d;
    logic [7:0]  ovfCnt_q, ovfCnt_d;

    logic        ctrlTraps;
    logic        isMulDiv;
    logic        trap;

    assign ctrlTraps = (CTRL == OP_MUL) || (CTRL == OP_SUB) || (CTRL == OP_ADD);
    assign isMulDiv  = (CTRL == OP_MUL) || (CTRL == OP_DIV);

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        result_d  = result_q;
        rem_d     = rem_q;
        store_d   = store_q;
        dest_d    = dest_q;
        regW_d    = regW_q;
        memR_d    = memR_q;
        memW_d    = memW_q;
        r15W_d    = r15W_q;
        excReq_d  = excReq_q;
        excCode_d = excCode_q;
        ovfCnt_d  = ovfCnt_q;
        trap      = 1'b0;

        // A bubble leaves data as-is; only valid and the enables matter downstream.
        if (state_q == EXC_HOLD || Flush) begin
            valid_d = 1'b0;
            regW_d  = 1'b0;
            memR_d  = 1'b0;
            memW_d  = 1'b0;
            r15W_d  = 1'b0;
            if (state_q == EXC_HOLD && Exc_ack) begin
                state_d   = RUN;
                excReq_d  = 1'b0;
                excCode_d = 2'b00;
            end
        end else if (!Stall) begin
            trap     = EX_valid && Overflow_flag && ctrlTraps;
            valid_d  = EX_valid;
            result_d = ALU_Result;
            rem_d    = Remainder;
            store_d  = EX_StoreData;
            dest_d   = EX_dest;
            regW_d   = EX_valid && EX_RegWrite && !trap;
            memR_d   = EX_valid && EX_MemRead;
            memW_d   = EX_valid && EX_MemWrite && !trap;
            r15W_d   = EX_valid && isMulDiv && !trap;
            if (trap) begin
                state_d   = EXC_HOLD;
                excReq_d  = 1'b1;
                excCode_d = (CTRL == OP_MUL) ? 2'b10 : 2'b01;
                if (ovfCnt_q != 8'hFF) begin
                    ovfCnt_d = ovfCnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            valid_q   <= 1'b0;
            result_q  <= 16'd0;
            rem_q     <= 16'd0;
            store_q   <= 16'd0;
            dest_q    <= 4'd0;
            regW_q    <= 1'b0;
            memR_q    <= 1'b0;
            memW_q    <= 1'b0;
            r15W_q    <= 1'b0;
            excReq_q  <= 1'b0;
            excCode_q <= 2'b00;
            ovfCnt_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            rem_q     <= rem_d;
            store_q   <= store_d;
            dest_q    <= dest_d;
            regW_q    <= regW_d;
            memR_q    <= memR_d;
            memW_q    <= memW_d;
            r15W_q    <= r15W_d;
            excReq_q  <= excReq_d;
            excCode_q <= excCode_d;
            ovfCnt_q  <= ovfCnt_d;
        end
    end

    assign MEM_valid     = valid_q;
    assign MEM_Result    = result_q;
    assign MEM_Remainder = rem_q;
    assign MEM_StoreData = store_q;
    assign MEM_dest      = dest_q;
    assign MEM_RegWrite  = regW_q;
    assign MEM_MemRead   = memR_q;
    assign MEM_MemWrite  = memW_q;
    assign MEM_R15Write  = r15W_q;
    assign Busy          = (state_q == EXC_HOLD);
    assign Exc_req       = excReq_q;
    assign Exc_code      = excCode_q;
    assign Ovf_count     = ovfCnt_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the pipeline register.
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        EX_valid, Overflow_flag, EX_RegWrite, EX_MemRead, EX_MemWrite;
    logic [3:0]  CTRL, EX_dest;
    logic [15:0] ALU_Result, Remainder, EX_StoreData;
    logic        Stall, Flush, Exc_ack;
    logic        MEM_valid, MEM_RegWrite, MEM_MemRead, MEM_MemWrite, MEM_R15Write;
    logic [15:0] MEM_Result, MEM_Remainder, MEM_StoreData;
    logic [3:0]  MEM_dest;
    logic        Busy, Exc_req;
    logic [1:0]  Exc_code;
    logic [7:0]  Ovf_count;

    int checks = 0;
    int errors = 0;

    // Behavioural expectation of everything visible after the most recent edge.
    bit          inHandler;
    bit          expValid, expRegW, expMemR, expMemW, expR15W, expReq;
    logic [15:0] expResult, expRem, expStore;
    logic [3:0]  expDest;
    logic [1:0]  expCode;
    int          trapCount;

    ex_mem_reg dut (
        .clk(clk), .rst(rst),
        .EX_valid(EX_valid), .CTRL(CTRL), .ALU_Result(ALU_Result), .Remainder(Remainder),
        .Overflow_flag(Overflow_flag), .EX_dest(EX_dest), .EX_RegWrite(EX_RegWrite),
        .EX_MemRead(EX_MemRead), .EX_MemWrite(EX_MemWrite), .EX_StoreData(EX_StoreData),
        .Stall(Stall), .Flush(Flush), .Exc_ack(Exc_ack),
        .MEM_valid(MEM_valid), .MEM_Result(MEM_Result), .MEM_Remainder(MEM_Remainder),
        .MEM_StoreData(MEM_StoreData), .MEM_dest(MEM_dest), .MEM_RegWrite(MEM_RegWrite),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .MEM_R15Write(MEM_R15Write),
        .Busy(Busy), .Exc_req(Exc_req), .Exc_code(Exc_code), .Ovf_count(Ovf_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        inHandler = 0; expValid = 0; expRegW = 0; expMemR = 0; expMemW = 0; expR15W = 0;
        expReq = 0; expCode = 2'b00; trapCount = 0;
        expResult = 16'd0; expRem = 16'd0; expStore = 16'd0; expDest = 4'd0;
    endtask

    task automatic modelBubble();
        expValid = 0; expRegW = 0; expMemR = 0; expMemW = 0; expR15W = 0;
    endtask

    // What the next rising edge should do with the inputs currently applied.
    task automatic modelStep();
        bit overflowOp, traps;
        overflowOp = (CTRL == 4'd1) || (CTRL == 4'd14) || (CTRL == 4'd15);
        if (inHandler) begin
            modelBubble();
            if (Exc_ack) begin
                inHandler = 0; expReq = 0; expCode = 2'b00;
            end
        end else if (Flush) begin
            modelBubble();
        end else if (!Stall) begin
            traps     = EX_valid && Overflow_flag && overflowOp;
            expValid  = EX_valid;
            expResult = ALU_Result;
            expRem    = Remainder;
            expStore  = EX_StoreData;
            expDest   = EX_dest;
            expRegW   = EX_valid && EX_RegWrite && !traps;
            expMemR   = EX_valid && EX_MemRead;
            expMemW   = EX_valid && EX_MemWrite && !traps;
            expR15W   = EX_valid && (CTRL == 4'd1 || CTRL == 4'd2) && !traps;
            if (traps) begin
                inHandler = 1;
                expReq    = 1;
                expCode   = (CTRL == 4'd1) ? 2'b10 : 2'b01;
                trapCount = trapCount + 1;
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("MEM_valid", MEM_valid, expValid);
        checkOutput("MEM_RegWrite", MEM_RegWrite, expRegW);
        checkOutput("MEM_MemRead", MEM_MemRead, expMemR);
        checkOutput("MEM_MemWrite", MEM_MemWrite, expMemW);
        checkOutput("MEM_R15Write", MEM_R15Write, expR15W);
        checkOutput("Busy", Busy, inHandler);
        checkOutput("Exc_req", Exc_req, expReq);
        checkOutput("Exc_code", Exc_code, expCode);
        checkOutput("Ovf_count", Ovf_count, (trapCount > 255) ? 255 : trapCount);
        if (expValid) begin
            checkOutput("MEM_Result", MEM_Result, expResult);
            checkOutput("MEM_Remainder", MEM_Remainder, expRem);
            checkOutput("MEM_StoreData", MEM_StoreData, expStore);
            checkOutput("MEM_dest", MEM_dest, expDest);
        end
    endtask

    // Inputs are applied on a falling edge; the next rising edge acts on them.
    task automatic applyStimulus();
        modelStep();
        @(negedge clk);
        checkAll();
    endtask

    task automatic setIdle();
        EX_valid = 0; CTRL = 4'd0; ALU_Result = 16'd0; Remainder = 16'd0; Overflow_flag = 0;
        EX_dest = 4'd0; EX_RegWrite = 0; EX_MemRead = 0; EX_MemWrite = 0; EX_StoreData = 16'd0;
        Stall = 0; Flush = 0; Exc_ack = 0;
    endtask

    task automatic setOp(input logic [3:0] op, input logic [15:0] res, input logic [15:0] rem,
                         input logic ovf, input logic [3:0] dest);
        EX_valid = 1; CTRL = op; ALU_Result = res; Remainder = rem; Overflow_flag = ovf;
        EX_dest = dest; EX_RegWrite = 1; EX_MemRead = 0; EX_MemWrite = 0; EX_StoreData = 16'd0;
    endtask

    task automatic randomInputs();
        logic [3:0] ops [4];
        ops[0] = 4'd1; ops[1] = 4'd2; ops[2] = 4'd14; ops[3] = 4'd15;
        EX_valid      = ($urandom_range(0, 9) < 8);
        CTRL          = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ops[$urandom_range(0, 3)];
        ALU_Result    = 16'($urandom);
        Remainder     = 16'($urandom);
        EX_StoreData  = 16'($urandom);
        EX_dest       = 4'($urandom);
        Overflow_flag = ($urandom_range(0, 9) < 3);
        EX_RegWrite   = 1'($urandom);
        EX_MemRead    = 1'($urandom);
        EX_MemWrite   = 1'($urandom);
        Stall         = ($urandom_range(0, 99) < 15);
        Flush         = ($urandom_range(0, 99) < 10);
        Exc_ack       = ($urandom_range(0, 99) < 40);
    endtask

    initial begin
        setIdle();
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkAll();
        checkOutput("reset_Result", MEM_Result, 0);
        rst = 1'b0;

        // ADD pass-through and DIV with R15 write.
        setOp(4'd15, 16'd1050, 16'd0, 0, 4'd3);
        applyStimulus();
        checkOutput("add_Result", MEM_Result, 1050);
        checkOutput("add_dest", MEM_dest, 3);
        checkOutput("add_RegWrite", MEM_RegWrite, 1);
        checkOutput("add_R15Write", MEM_R15Write, 0);
        setOp(4'd2, 16'd20, 16'd0, 0, 4'd4);
        applyStimulus();
        checkOutput("div_Result", MEM_Result, 20);
        checkOutput("div_Remainder", MEM_Remainder, 0);
        checkOutput("div_R15Write", MEM_R15Write, 1);

        // ADD overflow trap, three ignored cycles, then acknowledge.
        setOp(4'd15, 16'h7FFF, 16'd0, 1, 4'd5);
        applyStimulus();
        checkOutput("trap_RegWrite", MEM_RegWrite, 0);
        checkOutput("trap_valid", MEM_valid, 1);
        checkOutput("trap_req", Exc_req, 1);
        checkOutput("trap_code", Exc_code, 2'b01);
        checkOutput("trap_Busy", Busy, 1);
        checkOutput("trap_count", Ovf_count, 1);
        for (int i = 0; i < 3; i++) begin
            setOp(4'd15, 16'(100 + i), 16'd0, 0, 4'd6);
            applyStimulus();
            checkOutput("hold_valid", MEM_valid, 0);
            checkOutput("hold_code", Exc_code, 2'b01);
        end
        Exc_ack = 1;
        applyStimulus();
        checkOutput("ack_req", Exc_req, 0);
        checkOutput("ack_Busy", Busy, 0);
        Exc_ack = 0;

        // Stall holds, then Stall+Flush squashes.
        setOp(4'd15, 16'h00AA, 16'd0, 0, 4'd7);
        applyStimulus();
        for (int i = 0; i < 2; i++) begin
            setOp(4'd14, 16'(16'h1234 + i), 16'd0, 1, 4'd8);
            Stall = 1;
            applyStimulus();
            checkOutput("stall_Result", MEM_Result, 16'h00AA);
            checkOutput("stall_noTrap", Exc_req, 0);
        end
        Flush = 1;
        applyStimulus();
        checkOutput("flush_valid", MEM_valid, 0);
        checkOutput("flush_noTrap", Busy, 0);
        setIdle();

        // MUL trap, then asynchronous reset between edges.
        setOp(4'd1, 16'hFFFF, 16'h0001, 1, 4'd9);
        applyStimulus();
        checkOutput("mul_code", Exc_code, 2'b10);
        setIdle();
        #2 rst = 1'b1;
        #1;
        checkOutput("async_req", Exc_req, 0);
        checkOutput("async_Busy", Busy, 0);
        checkOutput("async_count", Ovf_count, 0);
        modelReset();
        #1 rst = 1'b0;
        applyStimulus();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            randomInputs();
            applyStimulus();
        end

        // Saturation: 256 acknowledged traps from a clean count.
        setIdle();
        @(negedge clk);
        rst = 1'b1;
        #1 modelReset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            setOp(4'd14, 16'(i), 16'd0, 1, 4'd1);
            applyStimulus();
            setIdle();
            Exc_ack = 1;
            applyStimulus();
            Exc_ack = 0;
        end
        checkOutput("sat_count", Ovf_count, 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have ports, clock and reset first, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- EX_valid  in  1  EX stage holds a real instruction.
- CTRL  in  4  ALU opcode of the EX instruction: 1 MUL, 2 DIV, 14 SUB, 15 ADD; other values do not trap.
- ALU_Result  in  16  ALU primary result.
- Remainder  in  16  DIV remainder or MUL high word.
- Overflow_flag  in  1  ALU overflow indication.
- EX_dest  in  4  destination register index.
- EX_RegWrite, EX_MemRead, EX_MemWrite  in  1 each  EX control bits.
- EX_StoreData  in  16  store data.
- Stall  in  1  hold the MEM-side register.
- Flush  in  1  squash the EX instruction.
- Exc_ack  in  1  exception handler acknowledge.
- MEM_valid  out  1  MEM register holds a real instruction.
- MEM_Result, MEM_Remainder, MEM_StoreData  out  16 each  registered copies.
- MEM_dest  out  4  registered destination index.
- MEM_RegWrite, MEM_MemRead, MEM_MemWrite  out  1 each  registered controls, gated by valid.
- MEM_R15Write  out  1  write MEM_Remainder into R15.
- Busy  out  1  upstream must stall.
- Exc_req  out  1  overflow exception request.
- Exc_code  out  2  01 ADD/SUB overflow, 10 MUL overflow, 00 none.
- Ovf_count  out  8  saturating count of trapped overflows.

Function
REQ-002 SHALL implement FSM states RUN and EXC_HOLD; Busy = (state == EXC_HOLD).
REQ-003 SHALL, in RUN with Stall=0 and Flush=0, capture all EX inputs into the MEM outputs on the clock edge: latency exactly 1 cycle.
REQ-004 SHALL, when Stall=1 and Flush=0, hold every MEM output and the FSM state unchanged.
REQ-005 SHALL, when Flush=1, load a bubble regardless of Stall: MEM_valid=0 and every MEM control and write-enable output 0; data outputs are don't-care.
REQ-006 SHALL force MEM_RegWrite, MEM_MemRead, MEM_MemWrite and MEM_R15Write to 0 whenever the captured instruction is not valid.
REQ-007 SHALL set MEM_R15Write=1 for a valid captured instruction with CTRL=1 or CTRL=2 and no trap; otherwise 0.
REQ-008 SHALL define a trap as a capture in RUN with EX_valid=1, Overflow_flag=1 and CTRL in {1, 14, 15}; Overflow_flag with any other CTRL is ignored.
REQ-009 SHALL, on a trap:
- capture the instruction with MEM_valid=1 and MEM_RegWrite, MEM_MemWrite and MEM_R15Write all 0;
- set Exc_req=1 with Exc_code per REQ-001;
- move to EXC_HOLD.
REQ-010 SHALL, in EXC_HOLD, load a bubble every cycle irrespective of EX inputs and Stall, and keep Exc_req and Exc_code stable.
REQ-011 SHALL, on Exc_ack=1 in EXC_HOLD, clear Exc_req to 0 and Exc_code to 00 and return to RUN on that edge; Exc_ack in RUN is ignored.
REQ-012 SHALL increment Ovf_count by 1 per trap, saturating at 255 with no wrap.
REQ-013 SHALL give Flush priority over a trap: a flushed overflowing instruction does not trap.
REQ-014 SHALL not trap while Stall=1, because no capture occurs.

Reset
REQ-015 SHALL, on rst=1 asynchronously and at any time including mid-EXC_HOLD, reset as follows:
- state RUN;
- every 1-bit output 0 and every multi-bit output 0, including MEM_* data, Exc_code and Ovf_count;
- Busy=0.

Verification
REQ-016 ADD pass-through: EX_valid=1, CTRL=15, ALU_Result=1050, EX_RegWrite=1, EX_dest=3 -> next cycle MEM_Result=1050, MEM_dest=3, MEM_RegWrite=1, MEM_R15Write=0.
REQ-017 DIV: CTRL=2, ALU_Result=20, Remainder=0 -> MEM_Result=20, MEM_Remainder=0, MEM_R15Write=1.
REQ-018 ADD trap: CTRL=15, Overflow_flag=1 -> MEM_RegWrite=0, Exc_req=1, Exc_code=01, Busy=1, Ovf_count=1. Then 3 cycles of valid inputs -> MEM_valid=0 throughout. Then Exc_ack=1 -> Exc_req=0 and Busy=0 on the next edge.
REQ-019 Stall then Flush: capture ALU_Result=0x00AA, apply Stall=1 for 2 cycles with new inputs -> MEM_Result stays 0x00AA; then Stall=1 and Flush=1 together -> MEM_valid=0.
REQ-020 Reset in EXC_HOLD: trap via CTRL=1, then pulse rst between clock edges -> Exc_req=0, Busy=0 and Ovf_count=0 immediately, without waiting for a clock edge.
REQ-021 Saturation: apply 256 traps, each acknowledged -> Ovf_count=255.
